// File: rtl/fc_inference_sequencer.sv
// fc_inference_sequencer: clears, feeds and reads one fully-connected layer per image, then argmaxes its scores. Rev 1.0
// Optional build macro FC_SEQ_TIMEOUT_EN adds a COMPUTE watchdog that drives the sticky error flag.
`default_nettype none

module fc_inference_sequencer #(
  parameter int BITS_INT = 4,
  parameter int BITS_FRC = 12,
  parameter int WIDTH    = 784,
  parameter int HEIGHT   = 10,
  parameter int TIMEOUT  = 1023
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        pix_valid,
  output logic                                        pix_ready,
  input  logic [BITS_INT+BITS_FRC-1:0]                pix_data,
  output logic                                        fc_rst_n,
  output logic [9:0]                                  fc_counter,
  output logic [BITS_INT+BITS_FRC-1:0]                fc_pixel,
  input  logic                                        fc_done,
  input  logic [HEIGHT-1:0][BITS_INT+BITS_FRC-1:0]    fc_out,
  output logic                                        busy,
  output logic                                        result_valid,
  input  logic                                        result_ready,
  output logic [3:0]                                  result_digit,
  output logic [BITS_INT+BITS_FRC-1:0]                result_score,
  output logic                                        error
);

  localparam int         DW       = BITS_INT + BITS_FRC;
  localparam logic [9:0] LAST_PIX = 10'(WIDTH - 1);
  localparam logic [3:0] LAST_IDX = 4'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPUTE = 3'd3,
    S_ARGMAX  = 3'd4,
    S_RESULT  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic                   pix_ready_q, pix_ready_d;
  logic                   fc_rst_n_q, fc_rst_n_d;
  logic [9:0]             fc_counter_q, fc_counter_d;
  logic [DW-1:0]          fc_pixel_q, fc_pixel_d;
  logic                   busy_q, busy_d;
  logic                   result_valid_q, result_valid_d;
  logic [3:0]             result_digit_q, result_digit_d;
  logic [DW-1:0]          result_score_q, result_score_d;
  logic                   error_q, error_d;
  logic signed [DW-1:0]   score_q [HEIGHT];
  logic signed [DW-1:0]   score_d [HEIGHT];
  logic [3:0]             arg_i_q, arg_i_d;
  logic [3:0]             best_i_q, best_i_d;
  logic signed [DW-1:0]   best_q, best_d;
  logic                   take;

`ifdef FC_SEQ_TIMEOUT_EN
  logic [9:0]             tmo_cnt_q, tmo_cnt_d;
`else
  logic                   unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign pix_ready    = pix_ready_q;
  assign fc_rst_n     = fc_rst_n_q;
  assign fc_counter   = fc_counter_q;
  assign fc_pixel     = fc_pixel_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_digit = result_digit_q;
  assign result_score = result_score_q;
  assign error        = error_q;

  always_comb begin
    state_d        = state_q;
    fc_counter_d   = fc_counter_q;
    fc_pixel_d     = fc_pixel_q;
    result_digit_d = result_digit_q;
    result_score_d = result_score_q;
    error_d        = error_q;
    score_d        = score_q;
    arg_i_d        = arg_i_q;
    best_i_d       = best_i_q;
    best_d         = best_q;
    // First entry always seeds the running best; later ones must be strictly greater.
    take           = (arg_i_q == 4'd0) || (score_q[arg_i_q] > best_q);
`ifdef FC_SEQ_TIMEOUT_EN
    tmo_cnt_d      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        fc_counter_d = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        fc_counter_d = '0;
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        if (pix_valid && pix_ready_q) begin
          fc_pixel_d   = pix_data;
          fc_counter_d = fc_counter_q + 10'd1;
          if (fc_counter_q == LAST_PIX) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (fc_done) begin
          for (int i = 0; i < HEIGHT; i++) score_d[i] = fc_out[i];
          arg_i_d = '0;
          state_d = S_ARGMAX;
        end
`ifdef FC_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == 10'(TIMEOUT - 1)) begin
          error_d        = 1'b1;
          result_digit_d = 4'hF;
          result_score_d = '0;
          state_d        = S_RESULT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
`endif
      end
      S_ARGMAX: begin
        if (take) begin
          best_d   = score_q[arg_i_q];
          best_i_d = arg_i_q;
        end
        if (arg_i_q == LAST_IDX) begin
          result_digit_d = LAST_IDX - (take ? arg_i_q : best_i_q);
          result_score_d = take ? score_q[arg_i_q] : best_q;
          state_d        = S_RESULT;
        end else begin
          arg_i_d = arg_i_q + 4'd1;
        end
      end
      S_RESULT: begin
        if (result_ready) begin
          fc_counter_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they register in step with it.
    pix_ready_d    = (state_d == S_LOAD);
    fc_rst_n_d     = (state_d != S_CLEAR);
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      pix_ready_q    <= 1'b0;
      fc_rst_n_q     <= 1'b0;
      fc_counter_q   <= '0;
      fc_pixel_q     <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_digit_q <= '0;
      result_score_q <= '0;
      error_q        <= 1'b0;
      for (int i = 0; i < HEIGHT; i++) score_q[i] <= '0;
      arg_i_q        <= '0;
      best_i_q       <= '0;
      best_q         <= '0;
`ifdef FC_SEQ_TIMEOUT_EN
      tmo_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pix_ready_q    <= pix_ready_d;
      fc_rst_n_q     <= fc_rst_n_d;
      fc_counter_q   <= fc_counter_d;
      fc_pixel_q     <= fc_pixel_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_digit_q <= result_digit_d;
      result_score_q <= result_score_d;
      error_q        <= error_d;
      for (int i = 0; i < HEIGHT; i++) score_q[i] <= score_d[i];
      arg_i_q        <= arg_i_d;
      best_i_q       <= best_i_d;
      best_q         <= best_d;
`ifdef FC_SEQ_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: doc/fc_inference_sequencer.md
Name: fc_inference_sequencer

Overview:
- Controller that sequences one full_connected_layer instance per image: clears it, streams 784 pixels into it via its counter/input_pixel interface, waits for its done flag, then captures the 10 class scores.
- Runs a sequential argmax over the scores and presents the predicted digit on a valid/ready result port.
- Sits between the pixel source (camera/UART front end) and the result consumer (display/UART TX).

Parameters:
- BITS_INT, 4, integer bits of pixel and score fixed-point values
- BITS_FRC, 12, fractional bits of pixel and score values
- WIDTH, 784, pixels per image
- HEIGHT, 10, number of classes / layer outputs
- TIMEOUT, 1023, maximum COMPUTE cycles before error (used only with FC_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a new image when idle
- pix_valid  in  1  pixel source has data
- pix_ready  out  1  sequencer accepts a pixel this cycle
- pix_data  in  BITS_INT+BITS_FRC  pixel value, signed fixed point
- fc_rst_n  out  1  active-low clear to the layer (resets MAC accumulators)
- fc_counter  out  10  drives layer counter input
- fc_pixel  out  BITS_INT+BITS_FRC  drives layer input_pixel
- fc_done  in  1  layer done flag
- fc_out  in  HEIGHT x (BITS_INT+BITS_FRC)  layer outputs; index i holds class HEIGHT-1-i
- busy  out  1  high in every state except IDLE
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_digit  out  4  predicted class
- result_score  out  BITS_INT+BITS_FRC  winning score
- error  out  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except fc_rst_n=0. fc_rst_n is held low while reset is low and returns to 1 in IDLE.
  - Reset mid-operation abandons the image with no result.
- IDLE:
  - fc_counter=0, fc_rst_n=1, pix_ready=0.
  - start=1 moves to CLEAR. start is ignored in all other states.
- CLEAR: fc_rst_n=0 for exactly 1 cycle, internal pixel index k=0, then LOAD.
- LOAD:
  - pix_ready=1. A pixel is accepted when pix_valid&pix_ready.
  - On accepting pixel k, the next cycle has fc_pixel=pix_data and fc_counter=k+1 (registered, 1-cycle latency).
  - When no pixel is accepted, fc_counter and fc_pixel hold their values.
  - Source stalls (pix_valid=0) are allowed at any point.
  - After pixel WIDTH-1 is accepted, pix_ready drops on the next cycle and the state moves to COMPUTE.
- COMPUTE:
  - fc_counter is held at WIDTH for the whole state. The layer aborts if the counter changes, so this hold is mandatory.
  - On fc_done=1, the cycle captures fc_out[0..HEIGHT-1] into internal score registers and moves to ARGMAX.
  - Expected layer latency from fc_counter==WIDTH to fc_done is about WIDTH+2 cycles.
- ARGMAX:
  - One comparison per cycle, i=0..HEIGHT-1, so HEIGHT cycles total.
  - Comparison is signed. An entry replaces the current best only if strictly greater.
  - On ties, the lowest i wins, which means the highest digit wins.
  - result_digit = HEIGHT-1-best_i.
  - Then RESULT.
- RESULT:
  - result_valid=1. result_digit and result_score are stable while valid.
  - On result_valid&result_ready, result_valid drops next cycle, fc_counter returns to 0, and the state goes to IDLE.
  - With result_ready held high, RESULT lasts exactly 1 cycle.
- busy=1 in CLEAR, LOAD, COMPUTE, ARGMAX and RESULT.
- Widths: the pixel count register is 10 bits and never exceeds WIDTH. fc_counter never exceeds WIDTH.

Optional Feature:
- Macro: FC_SEQ_TIMEOUT_EN.
- Defined:
  - A 10-bit COMPUTE cycle counter is active.
  - If TIMEOUT cycles elapse without fc_done, error is set and stays set until reset.
  - The state goes to RESULT with result_digit=4'hF and result_score=0, then follows the normal handshake.
- Undefined:
  - No counter is built and error is tied to 0.
  - COMPUTE waits indefinitely for fc_done.

Test Plan:
- Reset/start:
  - Assert reset for 3 cycles -> all outputs 0 and fc_rst_n=0.
  - Release reset, then pulse start -> fc_rst_n low for exactly 1 cycle, then pix_ready=1.
- Load:
  - Stream 784 pixels with pix_data=k, pix_valid held high -> fc_counter steps 1..784 one cycle after each accept and fc_pixel equals the accepted data.
  - pix_ready is 0 after the 784th accept.
- Stall:
  - Hold pix_valid low for 5 cycles after pixel 100 -> fc_counter stays 101 and fc_pixel is unchanged.
  - The load completes with the correct count.
- Argmax:
  - Layer model returns fc_out={0x0100, 0xF000, 0x2000, 0x1FFF, 0, …, 0} at fc_done -> result_digit=7 (index 2) and result_score=0x2000, valid exactly HEIGHT cycles after capture.
  - Tie: fc_out[3]=fc_out[5]=0x1000 with all others negative -> result_digit=6 (index 3).
- Handshake/abort:
  - Hold result_ready=0 for 10 cycles -> result_valid and outputs stable; then ready=1 -> IDLE next cycle with fc_counter=0.
  - Drive reset low mid-LOAD -> IDLE with no result_valid.
- Timeout (FC_SEQ_TIMEOUT_EN, TIMEOUT=50):
  - Keep fc_done=0 -> error=1 and result_digit=F after 50 COMPUTE cycles.
  - error remains set through the next start until reset.
